exec_sched: RTL
===============

EXEC_SCHED -- requirements
Module: exec_sched

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous abort of the in-flight operation.
REQ-005 SHALL have port in_valid  input  1  issue request.
REQ-006 SHALL have port in_ready  output  1  issue accepted when in_valid && in_ready.
REQ-007 SHALL have port in_kind  input  3  exec_kind_t: K_ALU, K_DIV, K_DIVU, K_REM, K_REMU.
REQ-008 SHALL have port in_rd  input  5  destination register tag.
REQ-009 SHALL have port in_a, in_b  input  XLEN  dividend/divisor for divide kinds; ignored for K_ALU.
REQ-010 SHALL have port alu_enabled  output  1  enable to the single-cycle ALU.
REQ-011 SHALL have port alu_result  input  XLEN  registered ALU output.
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  writeback accepts the result.
REQ-014 SHALL have port out_rd, out_result  output  5, XLEN  tag and value of the held result.
REQ-015 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ALU_WAIT, DIV_RUN, HOLD.
REQ-017 in_ready SHALL equal !flush && (state==IDLE || (state==HOLD && out_ready)).
REQ-018 alu_enabled SHALL be combinational: in_valid && in_ready && in_kind==K_ALU.
REQ-019 K_ALU accept SHALL go to ALU_WAIT; the next edge captures alu_result into out_result and goes to HOLD (out_valid 1 cycle after accept).
REQ-020 Divide accept with in_b==0 SHALL go directly to HOLD: quotient all-ones, remainder in_a.
REQ-021 K_DIV/K_REM accept with in_a==32'h80000000 and in_b==32'hFFFFFFFF SHALL go directly to HOLD: quotient 32'h80000000, remainder 0.
REQ-022 Other divide accepts SHALL go to DIV_RUN: one restoring-division step per cycle on magnitudes, 32 steps, HOLD entered on the edge of step 32 (out_valid 32 cycles after accept).
REQ-023 Signed result fixup: quotient negated iff operand signs differ; remainder takes dividend sign.
REQ-024 out_rd SHALL be latched from in_rd at accept.
REQ-025 out_valid SHALL be 1 exactly in HOLD; out_result and out_rd stable while out_valid && !out_ready.
REQ-026 HOLD with out_ready and no new accept SHALL go to IDLE; with a simultaneous accept SHALL branch as from IDLE (back-to-back).
REQ-027 flush SHALL, from any state, go to IDLE next edge, abort the divider, drop out_valid; flush beats accept and out handshake in the same cycle.
REQ-028 in_valid in DIV_RUN/ALU_WAIT SHALL be ignored (in_ready low); no queuing.

Reset
REQ-029 rstn low SHALL immediately force: state IDLE, out_valid 0, out_rd 0, out_result 0, busy 0, step counter 0, divider idle.
REQ-030 Reset mid-DIV_RUN SHALL discard the operation with no output.

Structure
REQ-031 exec_kind_t and the FSM state enum SHALL live in the shared package def.sv.
REQ-032 Iteration SHALL be in sub-module div_iter (start, unsigned dividend/divisor, done, quotient, remainder); sign handling, special cases and FSM stay in exec_sched.

Verification
REQ-033 K_ALU accept, alu_result=32'h12345678 next cycle, out_ready=1 -> out_valid one cycle, out_result 32'h12345678, correct out_rd.
REQ-034 K_DIV -7/2 -> out_valid 32 cycles after accept, result 32'hFFFFFFFD; K_REM same operands -> 32'hFFFFFFFF.
REQ-035 K_DIVU 100/0 -> 1-cycle latency, 32'hFFFFFFFF; K_REMU 100/0 -> 100; K_DIV 0x80000000/-1 -> 0x80000000.
REQ-036 out_ready held low 5 cycles in HOLD -> out_valid, out_result, out_rd stable; simultaneous out_ready and new K_ALU accept -> back-to-back, no bubble.
REQ-037 flush at cycle 10 of DIV_RUN, and rstn low at cycle 20 of another -> IDLE, no out_valid, busy 0, next K_DIVU 9/3 -> 3.

Source files
------------

// File: rtl/def.sv
// Shared types for the execute scheduler: operation kinds and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package def;

    typedef enum logic [2:0] {
        K_ALU  = 3'd0,
        K_DIV  = 3'd1,
        K_DIVU = 3'd2,
        K_REM  = 3'd3,
        K_REMU = 3'd4
    } exec_kind_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALU_WAIT = 2'd1,
        DIV_RUN  = 2'd2,
        HOLD     = 2'd3
    } state_t;

endpackage

// File: rtl/exec_sched_if.sv
// Issue/writeback/ALU bundle between the issue stage and the execute scheduler.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on issue, out_valid/out_ready on writeback.
interface exec_sched_if import def::*; #(parameter int XLEN = 32) ();

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    exec_kind_t       in_kind;
    logic [4:0]       in_rd;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic             alu_enabled;
    logic [XLEN-1:0]  alu_result;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_rd;
    logic [XLEN-1:0]  out_result;
    logic             busy;

    // master: issue stage + ALU + writeback side
    modport master (
        output flush, in_valid, in_kind, in_rd, in_a, in_b, alu_result, out_ready,
        input  in_ready, alu_enabled, out_valid, out_rd, out_result, busy
    );

    // slave: the scheduler
    modport slave (
        input  flush, in_valid, in_kind, in_rd, in_a, in_b, alu_result, out_ready,
        output in_ready, alu_enabled, out_valid, out_rd, out_result, busy
    );

endinterface

// File: rtl/exec_sched_div_iter.sv
// Unsigned restoring divider, one quotient bit per clock, XLEN steps.
// Latency: start edge loads operands; done is high during the cycle whose edge performs step XLEN.
// Backpressure: none; start reloads at any time, abort returns it to idle.
// Ports: start/abort control, dividend/divisor in, done + post-step quotient/remainder out.
module div_iter #(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] rem_q, quo_q, dsr_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN:0]   shifted, diff;
    logic            ge;

    // Partial remainder shifted left with the next dividend bit; the
    // subtraction's borrow tells whether the divisor fits.
    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign diff      = shifted - {1'b0, dsr_q};
    assign ge        = ~diff[XLEN];

    // Outputs are the values after the step that happens at the coming edge,
    // so the owner can capture the final result on the same edge as the step.
    assign remainder = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quotient  = {quo_q[XLEN-2:0], ge};
    assign done      = (cnt_q == CW'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (abort) begin
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= CW'(XLEN);
        end else if (cnt_q != '0) begin
            rem_q <= remainder;
            quo_q <= quotient;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/exec_sched.sv
// Execute scheduler: single-cycle ALU handoff plus iterative signed/unsigned divide.
// Latency: ALU 1 cycle after accept, divide 32 cycles, divide-by-zero/overflow straight to HOLD.
// Backpressure: result held in HOLD until out_ready; no new issue accepted while ALU_WAIT/DIV_RUN.
// Ports: clk, rstn (async active-low), bus (exec_sched_if.slave: flush, issue, ALU, writeback, busy).
module exec_sched import def::*; #(parameter int XLEN = 32) (
    input  logic         clk,
    input  logic         rstn,
    exec_sched_if.slave  bus
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nxt;
    logic            accept, is_alu, is_signed, is_rem;
    logic            div_zero, div_ovf, div_special, div_start, div_done;
    logic            neg_q, neg_r, rem_sel;
    logic [XLEN-1:0] special_val, mag_a, mag_b;
    logic [XLEN-1:0] div_quo, div_rem, quo_fix, rem_fix, div_res;

    // Unrecognised kind encodings fall into the divide path as unsigned quotient.
    assign is_alu      = (bus.in_kind == K_ALU);
    assign is_signed   = (bus.in_kind == K_DIV) || (bus.in_kind == K_REM);
    assign is_rem      = (bus.in_kind == K_REM) || (bus.in_kind == K_REMU);

    assign div_zero    = (bus.in_b == '0);
    assign div_ovf     = is_signed && (bus.in_a == INT_MIN) && (bus.in_b == '1);
    assign div_special = div_zero || div_ovf;
    assign special_val = div_zero ? (is_rem ? bus.in_a : '1)
                                  : (is_rem ? '0       : INT_MIN);

    assign mag_a = (is_signed && bus.in_a[XLEN-1]) ? -bus.in_a : bus.in_a;
    assign mag_b = (is_signed && bus.in_b[XLEN-1]) ? -bus.in_b : bus.in_b;

    // HOLD can take a new op in the same cycle its result drains.
    assign bus.in_ready    = !bus.flush &&
                             ((state == IDLE) || ((state == HOLD) && bus.out_ready));
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.alu_enabled = accept && is_alu;
    assign div_start       = accept && !is_alu && !div_special;

    assign bus.out_valid   = (state == HOLD);
    assign bus.busy        = (state != IDLE);

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rstn      (rstn),
        .start     (div_start),
        .abort     (bus.flush),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Quotient negative iff operand signs differ; remainder follows the dividend.
    assign quo_fix = neg_q ? -div_quo : div_quo;
    assign rem_fix = neg_r ? -div_rem : div_rem;
    assign div_res = rem_sel ? rem_fix : quo_fix;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        if (is_alu)           state_nxt = ALU_WAIT;
                        else if (div_special) state_nxt = HOLD;
                        else                  state_nxt = DIV_RUN;
                    end else if ((state == HOLD) && bus.out_ready) begin
                        state_nxt = IDLE;
                    end
                end
                ALU_WAIT: state_nxt = HOLD;
                DIV_RUN:  if (div_done) state_nxt = HOLD;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.out_rd     <= '0;
            bus.out_result <= '0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            rem_sel        <= 1'b0;
        end else if (accept) begin
            bus.out_rd <= bus.in_rd;
            neg_q      <= is_signed && (bus.in_a[XLEN-1] ^ bus.in_b[XLEN-1]);
            neg_r      <= is_signed && bus.in_a[XLEN-1];
            rem_sel    <= is_rem;
            if (!is_alu && div_special) begin
                bus.out_result <= special_val;
            end
        end else if (!bus.flush) begin
            if (state == ALU_WAIT) begin
                bus.out_result <= bus.alu_result;
            end else if ((state == DIV_RUN) && div_done) begin
                bus.out_result <= div_res;
            end
        end
    end

endmodule
